fetch_sequencer: RTL and testbench

- Controls the program counter register and instruction-memory fetch for the RV32I core.
- Issues one fetch at a time over a req/ready handshake and advances the PC by 4.
- Applies branch/jump redirects and trap entry, and presents fetched instructions to decode over a valid/stall interface.
- Sits between the PC register, instruction memory and the decode stage.

---
 rtl/fetch_sequencer.sv | 156 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the RV32I core: owns the PC, runs one instruction-memory
// fetch at a time and hands fetched words to decode over a valid/stall interface.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          MAX_WAIT     = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  input  logic        Trap_Req,
  input  logic        Stall,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ready,
  input  logic [31:0] IMem_Rdata,
  output logic        Inst_Valid,
  output logic [31:0] Inst_Out,
  output logic [31:0] Inst_PC,
  output logic [31:0] PC_Out,
  output logic        Misalign_Fault,
  output logic        Timeout_Fault
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pend_target;
  logic        pend_valid;
  logic [7:0]  wait_cnt;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        misalign;
  logic        timeout;

  logic        hold_inst;
  logic        req;
  logic        done;
  logic        flush;
  logic        bad_target;
  logic [31:0] new_pc;
  logic        new_misalign;
  logic        timeout_hit;

  // A presented instruction that decode is stalling on blocks the next request,
  // so the held word is never overwritten by a later completion.
  assign hold_inst    = inst_valid & Stall;
  assign req          = (state == REQ) & ~hold_inst;
  assign done         = req & IMem_Ready;
  assign flush        = Trap_Req | Redirect_Valid;
  assign bad_target   = (Redirect_Target[1:0] != 2'b00);
  assign new_pc       = (Trap_Req | bad_target) ? TRAP_VECTOR : Redirect_Target;
  assign new_misalign = ~Trap_Req & Redirect_Valid & bad_target;
  assign timeout_hit  = req & ~IMem_Ready & (wait_cnt == WAIT_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      pend_target <= 32'h0;
      pend_valid  <= 1'b0;
      wait_cnt    <= 8'h0;
      inst_valid  <= 1'b0;
      inst_out    <= 32'h0;
      inst_pc     <= 32'h0;
      misalign    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (done) begin
            wait_cnt <= 8'h0;
            if (flush) begin
              pc         <= new_pc;
              pend_valid <= 1'b0;
              inst_valid <= 1'b0;
              misalign   <= new_misalign;
            end else if (pend_valid) begin
              // Word fetched from the stale address is dropped.
              pc         <= pend_target;
              pend_valid <= 1'b0;
              inst_valid <= 1'b0;
            end else begin
              inst_out   <= IMem_Rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + 32'd4;
              state      <= Stall ? HOLD : REQ;
            end
          end else if (req) begin
            inst_valid <= 1'b0;
            if (timeout_hit) begin
              state      <= FAULT;
              timeout    <= 1'b1;
              wait_cnt   <= 8'h0;
              pend_valid <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
              if (flush) begin
                pend_target <= new_pc;
                pend_valid  <= 1'b1;
                misalign    <= new_misalign;
              end
            end
          end else if (flush) begin
            pc         <= new_pc;
            pend_valid <= 1'b0;
            inst_valid <= 1'b0;
            misalign   <= new_misalign;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (flush) begin
            pc         <= new_pc;
            inst_valid <= 1'b0;
            misalign   <= new_misalign;
            state      <= REQ;
          end else if (!Stall) begin
            inst_valid <= 1'b0;
            state      <= REQ;
          end
        end
        FAULT: begin
          if (Trap_Req) begin
            pc      <= TRAP_VECTOR;
            timeout <= 1'b0;
            state   <= REQ;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign IMem_Req       = req;
  assign IMem_Addr      = pc;
  assign PC_Out         = pc;
  assign Inst_Valid     = inst_valid;
  assign Inst_Out       = inst_out;
  assign Inst_PC        = inst_pc;
  assign Misalign_Fault = misalign;
  assign Timeout_Fault  = timeout;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: sequential fetch, stall hold,
// pending redirect, misaligned redirect, trap priority, PC wrap and timeout.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Redirect_Valid = 1'b0;
  logic [31:0] Redirect_Target = 32'h0;
  logic        Trap_Req = 1'b0;
  logic        Stall = 1'b0;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ready = 1'b0;
  logic [31:0] IMem_Rdata;
  logic        Inst_Valid;
  logic [31:0] Inst_Out;
  logic [31:0] Inst_PC;
  logic [31:0] PC_Out;
  logic        Misalign_Fault;
  logic        Timeout_Fault;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 Clk = ~Clk;

  // Memory image: word 0 is addi x1,x0,5; every other word is tagged with its address.
  assign IMem_Rdata = (IMem_Addr == 32'h0) ? 32'h0050_0093 : {IMem_Addr[23:0], 8'h13};

  fetch_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
    .Trap_Req(Trap_Req), .Stall(Stall),
    .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
    .IMem_Ready(IMem_Ready), .IMem_Rdata(IMem_Rdata),
    .Inst_Valid(Inst_Valid), .Inst_Out(Inst_Out), .Inst_PC(Inst_PC),
    .PC_Out(PC_Out), .Misalign_Fault(Misalign_Fault), .Timeout_Fault(Timeout_Fault)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    @(negedge Clk);
    Reset_n = 1'b0;
    Redirect_Valid = 1'b0;
    Redirect_Target = 32'h0;
    Trap_Req = 1'b0;
    Stall = 1'b0;
    IMem_Ready = ready;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    #1;
    tests_run++;
    if ({IMem_Req, Inst_Valid, Misalign_Fault, Timeout_Fault} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {IMem_Req, Inst_Valid, Misalign_Fault, Timeout_Fault});
    end
    tests_run++;
    if ({PC_Out, Inst_Out, Inst_PC} !== 96'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: got pc=%h out=%h ipc=%h expected all 0", PC_Out, Inst_Out, Inst_PC);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr [4];
    logic [31:0] exp_ipc  [4];
    exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8; exp_addr[3] = 32'hC;
    exp_ipc[0]  = 32'h0; exp_ipc[1]  = 32'h0; exp_ipc[2]  = 32'h4; exp_ipc[3]  = 32'h8;
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (IMem_Addr !== exp_addr[i] || IMem_Req !== 1'b1) begin
        tests_failed++;
        $display("FAIL seq_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, IMem_Req, IMem_Addr, exp_addr[i]);
      end
      tests_run++;
      if (Inst_Valid !== (i > 0) || (i > 0 && Inst_PC !== exp_ipc[i])) begin
        tests_failed++;
        $display("FAIL seq_inst[%0d]: got valid=%b ipc=%h expected valid=%b ipc=%h", i, Inst_Valid, Inst_PC, i > 0, exp_ipc[i]);
      end
      $display("[TB] seq cycle %0d addr=%h valid=%b ipc=%h", i, IMem_Addr, Inst_Valid, Inst_PC);
    end
    tests_run++;
    if (Inst_Out !== 32'h0000_0813) begin
      tests_failed++;
      $display("FAIL seq_word: got %h expected 00000813", Inst_Out);
    end
  endtask

  task automatic test_stall();
    do_reset(1'b1);
    tick();
    tick();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (Inst_Valid !== 1'b1 || Inst_Out !== 32'h0050_0093 || Inst_PC !== 32'h0 || IMem_Req !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got v=%b out=%h ipc=%h req=%b expected v=1 out=00500093 ipc=0 req=0",
                 i, Inst_Valid, Inst_Out, Inst_PC, IMem_Req);
      end
      tick();
    end
    Stall = 1'b0;
    tick();
    tests_run++;
    if (Inst_Valid !== 1'b0 || IMem_Req !== 1'b1 || IMem_Addr !== 32'h4) begin
      tests_failed++;
      $display("FAIL stall_resume: got v=%b req=%b addr=%h expected v=0 req=1 addr=4", Inst_Valid, IMem_Req, IMem_Addr);
    end
    tick();
    tests_run++;
    if (Inst_Valid !== 1'b1 || Inst_PC !== 32'h4 || Inst_Out !== 32'h0000_0413) begin
      tests_failed++;
      $display("FAIL stall_next: got v=%b ipc=%h out=%h expected v=1 ipc=4 out=00000413", Inst_Valid, Inst_PC, Inst_Out);
    end
    $display("[TB] test_stall done");
  endtask

  task automatic test_pending_redirect();
    do_reset(1'b1);
    tick();
    tick();
    tick();
    IMem_Ready = 1'b0;
    tick();
    Redirect_Valid = 1'b1;
    Redirect_Target = 32'h40;
    tick();
    Redirect_Valid = 1'b0;
    #1;
    tests_run++;
    if (IMem_Addr !== 32'h8 || IMem_Req !== 1'b1 || Inst_Valid !== 1'b0 || Misalign_Fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL pend_hold: got addr=%h req=%b v=%b mis=%b expected addr=8 req=1 v=0 mis=0",
               IMem_Addr, IMem_Req, Inst_Valid, Misalign_Fault);
    end
    tick();
    IMem_Ready = 1'b1;
    #1;
    tests_run++;
    if (IMem_Addr !== 32'h8) begin
      tests_failed++;
      $display("FAIL pend_complete_addr: got %h expected 00000008", IMem_Addr);
    end
    tick();
    tests_run++;
    if (IMem_Addr !== 32'h40 || Inst_Valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL pend_discard: got addr=%h v=%b expected addr=40 v=0", IMem_Addr, Inst_Valid);
    end
    tick();
    tests_run++;
    if (Inst_Valid !== 1'b1 || Inst_PC !== 32'h40 || Inst_Out !== 32'h0000_4013) begin
      tests_failed++;
      $display("FAIL pend_fetch: got v=%b ipc=%h out=%h expected v=1 ipc=40 out=00004013", Inst_Valid, Inst_PC, Inst_Out);
    end
    $display("[TB] test_pending_redirect done");
  endtask

  task automatic test_misalign();
    do_reset(1'b1);
    tick();
    Redirect_Valid = 1'b1;
    Redirect_Target = 32'h42;
    tick();
    Redirect_Valid = 1'b0;
    #1;
    tests_run++;
    if (Misalign_Fault !== 1'b1 || IMem_Addr !== 32'h100 || Inst_Valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_pulse: got mis=%b addr=%h v=%b expected mis=1 addr=100 v=0", Misalign_Fault, IMem_Addr, Inst_Valid);
    end
    tick();
    tests_run++;
    if (Misalign_Fault !== 1'b0 || Inst_Valid !== 1'b1 || Inst_PC !== 32'h100 || Inst_Out !== 32'h0001_0013) begin
      tests_failed++;
      $display("FAIL misalign_after: got mis=%b v=%b ipc=%h out=%h expected mis=0 v=1 ipc=100 out=00010013",
               Misalign_Fault, Inst_Valid, Inst_PC, Inst_Out);
    end
    $display("[TB] test_misalign done");
  endtask

  task automatic test_trap_priority();
    do_reset(1'b1);
    tick();
    Trap_Req = 1'b1;
    Redirect_Valid = 1'b1;
    Redirect_Target = 32'h80;
    tick();
    Trap_Req = 1'b0;
    Redirect_Valid = 1'b0;
    #1;
    tests_run++;
    if (IMem_Addr !== 32'h100 || Misalign_Fault !== 1'b0 || Inst_Valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL trap_prio: got addr=%h mis=%b v=%b expected addr=100 mis=0 v=0", IMem_Addr, Misalign_Fault, Inst_Valid);
    end
    tick();
    tests_run++;
    if (Inst_Valid !== 1'b1 || Inst_PC !== 32'h100) begin
      tests_failed++;
      $display("FAIL trap_fetch: got v=%b ipc=%h expected v=1 ipc=100", Inst_Valid, Inst_PC);
    end
    $display("[TB] test_trap_priority done");
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    tick();
    Redirect_Valid = 1'b1;
    Redirect_Target = 32'hFFFF_FFFC;
    tick();
    Redirect_Valid = 1'b0;
    #1;
    tests_run++;
    if (IMem_Addr !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_addr: got %h expected fffffffc", IMem_Addr);
    end
    tick();
    tests_run++;
    if (PC_Out !== 32'h0 || Inst_PC !== 32'hFFFF_FFFC || Inst_Out !== 32'hFFFF_FC13) begin
      tests_failed++;
      $display("FAIL wrap_pc: got pc=%h ipc=%h out=%h expected pc=0 ipc=fffffffc out=fffffc13", PC_Out, Inst_PC, Inst_Out);
    end
    $display("[TB] test_wrap done");
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    tick();
    repeat (15) tick();
    tests_run++;
    if (IMem_Req !== 1'b1 || Timeout_Fault !== 1'b0 || IMem_Addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL timeout_early: got req=%b to=%b addr=%h expected req=1 to=0 addr=0", IMem_Req, Timeout_Fault, IMem_Addr);
    end
    tick();
    tests_run++;
    if (Timeout_Fault !== 1'b1 || IMem_Req !== 1'b0 || Inst_Valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_fault: got to=%b req=%b v=%b expected to=1 req=0 v=0", Timeout_Fault, IMem_Req, Inst_Valid);
    end
    tick();
    tests_run++;
    if (Timeout_Fault !== 1'b1 || IMem_Req !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_sticky: got to=%b req=%b expected to=1 req=0", Timeout_Fault, IMem_Req);
    end
    Trap_Req = 1'b1;
    tick();
    Trap_Req = 1'b0;
    #1;
    tests_run++;
    if (Timeout_Fault !== 1'b0 || IMem_Req !== 1'b1 || IMem_Addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL timeout_trap: got to=%b req=%b addr=%h expected to=0 req=1 addr=100", Timeout_Fault, IMem_Req, IMem_Addr);
    end
    tick();
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    tests_run++;
    if ({IMem_Req, Inst_Valid, Misalign_Fault, Timeout_Fault} !== 4'b0000 || PC_Out !== 32'h0 ||
        Inst_Out !== 32'h0 || Inst_PC !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got req=%b v=%b pc=%h out=%h ipc=%h expected all 0",
               IMem_Req, Inst_Valid, PC_Out, Inst_Out, Inst_PC);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    $display("[TB] test_timeout done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_pending_redirect();
    test_misalign();
    test_trap_priority();
    test_wrap();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
